// File: rtl/seven_seg_pkg.sv
// Shared types and glyph table for the multiplexed seven-segment driver.
// Glyphs are active-high {g,f,e,d,c,b,a}; pin polarity is applied later.
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t GLYPH_0   = 7'b0111111;
    localparam seg_t GLYPH_1   = 7'b0000110;
    localparam seg_t GLYPH_2   = 7'b1011011;
    localparam seg_t GLYPH_3   = 7'b1001111;
    localparam seg_t GLYPH_4   = 7'b1100110;
    localparam seg_t GLYPH_5   = 7'b1101101;
    localparam seg_t GLYPH_6   = 7'b1111101;
    localparam seg_t GLYPH_7   = 7'b0000111;
    localparam seg_t GLYPH_8   = 7'b1111111;
    localparam seg_t GLYPH_9   = 7'b1101111;
    localparam seg_t GLYPH_A   = 7'b1110111;
    localparam seg_t GLYPH_B   = 7'b1111100;
    localparam seg_t GLYPH_C   = 7'b0111001;
    localparam seg_t GLYPH_D   = 7'b1011110;
    localparam seg_t GLYPH_E   = 7'b1111001;
    localparam seg_t GLYPH_F   = 7'b1110001;
    localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg_glyph_decoder.sv
// Combinational code -> glyph decoder. BCD mode blanks codes 10-15;
// an explicit blank request overrides everything.
module seg_glyph_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_mode,
    input  logic       blank,
    output seg_t       seg
);

    // Table lookup, then mode/blank gating
    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            4'hF: seg = GLYPH_F;
            default: seg = SEG_BLANK;
        endcase
        if (blank || (!hex_mode && code > 4'd9))
            seg = SEG_BLANK;
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode display driver. Inputs are snapshotted
// once per scan frame so a digit never changes half-way through a frame.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    hex_mode_i,
    input  logic                    lz_blank_i,
    input  logic                    enable_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]                cnt;
    logic [IW-1:0]                idx;
    logic                         tick;
    logic                         wrap;
    logic                         wrap_q;
    logic [NUM_DIGITS-1:0][3:0]   sh_digits;
    logic [NUM_DIGITS-1:0]        sh_dp;
    logic                         sh_hex;
    logic                         sh_lz;
    logic [NUM_DIGITS-1:0]        lz_mask;
    logic [3:0]                   code;
    seg_t                         glyph;
    seg_t                         seg_lvl;
    logic                         dp_lvl;
    logic [NUM_DIGITS-1:0]        an_lvl;

    assign tick = (cnt == CNT_MAX);
    assign wrap = tick && (idx == IDX_MAX);

    // Slot prescaler: counts 0..CLK_DIV-1 and wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

    // Active digit index, advances once per slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idx <= '0;
        else if (tick)
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end

    // Tear-free snapshot of all display inputs at the end of each frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_hex    <= 1'b0;
            sh_lz     <= 1'b0;
        end else if (wrap) begin
            sh_digits <= digits_i;
            sh_dp     <= dp_i;
            sh_hex    <= hex_mode_i;
            sh_lz     <= lz_blank_i;
        end
    end

    // Frame pulse is delayed one extra cycle so it lines up with the
    // first pin cycle that shows the new snapshot (pins lag idx by one)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_q  <= 1'b0;
            frame_o <= 1'b0;
        end else begin
            wrap_q  <= wrap;
            frame_o <= wrap_q;
        end
    end

    // Leading-zero mask: a digit is blanked while it and all digits above
    // it are zero; digit 0 always stays visible
    always_comb begin : lz_scan
        logic run;
        run     = 1'b1;
        lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run        = run & (sh_digits[i] == 4'd0);
            lz_mask[i] = run & sh_lz & (i != 0);
        end
    end

    assign code = sh_digits[idx];

    seg_glyph_decoder u_dec (
        .code     (code),
        .hex_mode (sh_hex),
        .blank    (lz_mask[idx]),
        .seg      (glyph)
    );

    // Active-high pin levels before polarity; enable gates everything
    always_comb begin
        seg_lvl = SEG_BLANK;
        dp_lvl  = 1'b0;
        an_lvl  = '0;
        if (enable_i) begin
            seg_lvl = glyph;
            dp_lvl  = sh_dp[idx];
            an_lvl  = NUM_DIGITS'(1) << idx;
        end
    end

    // Output registers; the only place pin polarity is applied
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_o <= {7{SEG_ACTIVE_LOW}};
            dp_o  <= SEG_ACTIVE_LOW;
            an_o  <= {NUM_DIGITS{AN_ACTIVE_LOW}};
        end else begin
            seg_o <= seg_lvl ^ {7{SEG_ACTIVE_LOW}};
            dp_o  <= dp_lvl ^ SEG_ACTIVE_LOW;
            an_o  <= an_lvl ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with NUM_DIGITS=4, CLK_DIV=4.
// Expected pin values are hand-derived active-low glyphs.
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] digits = 16'h0;
    logic [3:0]  dp = 4'h0;
    logic        hex_mode = 1'b0;
    logic        lz_blank = 1'b0;
    logic        enable = 1'b1;
    logic [6:0]  seg;
    logic        dp_pin;
    logic [3:0]  an;
    logic        frame;

    int checks = 0;
    int failures = 0;
    int n;

    // Active-low pin patterns
    localparam logic [6:0] P_0 = 7'b1000000;
    localparam logic [6:0] P_1 = 7'b1111001;
    localparam logic [6:0] P_2 = 7'b0100100;
    localparam logic [6:0] P_3 = 7'b0110000;
    localparam logic [6:0] P_4 = 7'b0011001;
    localparam logic [6:0] P_7 = 7'b1111000;
    localparam logic [6:0] P_C = 7'b1000110;
    localparam logic [6:0] P_D = 7'b0100001;
    localparam logic [6:0] P_OFF = 7'b1111111;

    seven_seg_scanner #(
        .NUM_DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits_i   (digits),
        .dp_i       (dp),
        .hex_mode_i (hex_mode),
        .lz_blank_i (lz_blank),
        .enable_i   (enable),
        .seg_o      (seg),
        .dp_o       (dp_pin),
        .an_o       (an),
        .frame_o    (frame)
    );

    always #5 clk = ~clk;

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step until frame_o is seen (at least one step), bounded
    task automatic wait_frame(output int cycles);
        cycles = 0;
        do begin
            step(1);
            cycles++;
        end while (frame !== 1'b1 && cycles < 40);
        chk("frame_seen", 32'(frame), 32'd1);
    endtask

    initial begin
        // Reset state
        #1 reset = 1'b1;
        digits = 16'h1234; dp = 4'b0010; hex_mode = 1'b0; lz_blank = 1'b0; enable = 1'b1;
        #1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'(P_OFF));
        chk("rst_dp", 32'(dp_pin), 32'd1);
        chk("rst_frame", 32'(frame), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // First frame shows the zero shadow
        step(1);
        chk("zero_shadow_an", 32'(an), 32'hE);
        chk("zero_shadow_seg", 32'(seg), 32'(P_0));

        // BCD scan of 1234
        wait_frame(n);
        chk("bcd_d0_an", 32'(an), 32'hE);
        chk("bcd_d0_seg", 32'(seg), 32'(P_4));
        chk("bcd_d0_dp", 32'(dp_pin), 32'd1);
        step(1);
        chk("bcd_frame_one_cycle", 32'(frame), 32'd0);
        step(2);
        chk("bcd_d0_last_an", 32'(an), 32'hE);
        step(1);
        chk("bcd_d1_an", 32'(an), 32'hD);
        chk("bcd_d1_seg", 32'(seg), 32'(P_3));
        chk("bcd_d1_dp", 32'(dp_pin), 32'd0);
        step(4);
        chk("bcd_d2_an", 32'(an), 32'hB);
        chk("bcd_d2_seg", 32'(seg), 32'(P_2));
        step(4);
        chk("bcd_d3_an", 32'(an), 32'h7);
        chk("bcd_d3_seg", 32'(seg), 32'(P_1));

        // Asynchronous reset while digit 2 is active
        wait_frame(n);
        step(8);
        chk("pre_rst_an", 32'(an), 32'hB);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_an", 32'(an), 32'hF);
        chk("async_rst_seg", 32'(seg), 32'(P_OFF));
        chk("async_rst_dp", 32'(dp_pin), 32'd1);
        chk("async_rst_frame", 32'(frame), 32'd0);
        #2 reset = 1'b0;
        digits = 16'hABCD; hex_mode = 1'b1; dp = 4'b0000;
        step(1);
        chk("post_rst_zero_seg", 32'(seg), 32'(P_0));
        chk("post_rst_zero_an", 32'(an), 32'hE);

        // Hex mode
        wait_frame(n);
        chk("hex_d0_seg", 32'(seg), 32'(P_D));
        step(4);
        chk("hex_d1_seg", 32'(seg), 32'(P_C));
        // BCD mode on the same codes: all blank
        hex_mode = 1'b0;
        step(8);
        wait_frame(n);
        chk("bcd_abcd_d0", 32'(seg), 32'(P_OFF));
        step(4);
        chk("bcd_abcd_d1", 32'(seg), 32'(P_OFF));
        step(4);
        chk("bcd_abcd_d2", 32'(seg), 32'(P_OFF));
        step(4);
        chk("bcd_abcd_d3", 32'(seg), 32'(P_OFF));
        chk("bcd_abcd_d3_an", 32'(an), 32'h7);

        // Leading-zero blanking: 0070
        digits = 16'h0070; lz_blank = 1'b1;
        wait_frame(n);
        chk("lz70_d0", 32'(seg), 32'(P_0));
        step(4);
        chk("lz70_d1", 32'(seg), 32'(P_7));
        step(4);
        chk("lz70_d2", 32'(seg), 32'(P_OFF));
        chk("lz70_d2_an", 32'(an), 32'hB);
        step(4);
        chk("lz70_d3", 32'(seg), 32'(P_OFF));

        // All-zero: single "0"; dp unaffected by blanking
        digits = 16'h0000; dp = 4'b1000;
        wait_frame(n);
        chk("lz0_d0", 32'(seg), 32'(P_0));
        step(4);
        chk("lz0_d1", 32'(seg), 32'(P_OFF));
        step(8);
        chk("lz0_d3", 32'(seg), 32'(P_OFF));
        chk("lz0_d3_dp", 32'(dp_pin), 32'd0);

        // Tear-free capture
        digits = 16'h1111; dp = 4'b0000; lz_blank = 1'b0;
        wait_frame(n);
        step(4);
        chk("tear_d1_an", 32'(an), 32'hD);
        digits = 16'h2222;
        step(4);
        chk("tear_d2_old", 32'(seg), 32'(P_1));
        step(4);
        chk("tear_d3_old", 32'(seg), 32'(P_1));
        step(3);
        chk("tear_d3_last_old", 32'(seg), 32'(P_1));
        chk("tear_no_frame_yet", 32'(frame), 32'd0);
        step(1);
        chk("tear_frame", 32'(frame), 32'd1);
        chk("tear_new_seg", 32'(seg), 32'(P_2));
        chk("tear_new_an", 32'(an), 32'hE);

        // Enable
        step(1);
        enable = 1'b0;
        step(1);
        chk("dis_an", 32'(an), 32'hF);
        chk("dis_seg", 32'(seg), 32'(P_OFF));
        chk("dis_dp", 32'(dp_pin), 32'd1);
        wait_frame(n);
        chk("dis_first_frame_gap", 32'(n), 32'd14);
        wait_frame(n);
        chk("dis_frame_period", 32'(n), 32'd16);
        chk("dis_frame_an", 32'(an), 32'hF);
        enable = 1'b1;
        step(1);
        chk("reen_an_d0", 32'(an), 32'hE);
        chk("reen_seg_d0", 32'(seg), 32'(P_2));
        step(3);
        chk("reen_an_d1", 32'(an), 32'hD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
